fmul_pipe: RTL and testbench
============================

FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 Parameter EW, default 8, exponent field width in bits.
REQ-002 Parameter MW, default 23, stored mantissa field width in bits (hidden bit excluded).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair on x1/x2 is valid.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 x1, x2  input  1+EW+MW each  operands, packed {sign, exponent, mantissa}.
REQ-008 out_valid  output  1  result on y/ovf/unf is valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 y  output  1+EW+MW  product, same packing as the operands.
REQ-011 ovf, unf  output  1 each  overflow flag and underflow flag, qualified by out_valid.

Function
REQ-012 Transfers occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-013 Three-stage pipeline: S1 unpack, sign XOR, (MW+1)x(MW+1) mantissa product, exponent sum; S2 normalise, round; S3 exponent bias/range check, pack, flags.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready is held high; throughput one result per cycle.
REQ-015 Global stall: advance = ~out_valid | out_ready; in_ready = advance; when advance=0, all stage registers hold.
REQ-016 While out_valid=1 and out_ready=0, y/ovf/unf SHALL remain stable until the transfer.
REQ-017 Results leave in acceptance order; no operand is dropped or duplicated under any stall pattern.
REQ-018 A stage holding no valid operation propagates a bubble; bubbles never raise out_valid.
REQ-019 Input exponent 0 is treated as zero (denormals flushed); any zero operand gives signed zero {sx1^sx2, 0}, ovf=0, unf=0.
REQ-020 Product normalisation: if product MSB set, shift 0 and exponent +1; else shift left 1.
REQ-021 Rounding SHALL be round-to-nearest, ties-to-even; a rounding carry out of the mantissa renormalises and increments exponent.
REQ-022 Biased result exponent = e1 + e2 - (2^(EW-1)-1) + norm/round increments, computed in EW+2 bits signed.
REQ-023 Result exponent >= 2^EW-1: y = signed infinity {s, all-ones, 0}, ovf=1.
REQ-024 Result exponent <= 0 (non-zero operands): y = signed zero, unf=1.
REQ-025 Sign of y is always s1^s2, including zero, infinity and underflow results.

Reset
REQ-026 While rst=1: all stage valid bits 0, out_valid=0, y=0, ovf=0, unf=0; in_ready=1 one cycle after deassertion at latest.
REQ-027 Reset asserted mid-operation discards every in-flight operation; no result for it is ever produced.

Configuration
REQ-028 Macro FMUL_PIPE_SPECIAL_EN, when defined, enables IEEE special handling: exponent all-ones with mantissa!=0 is NaN; any NaN operand or infinity x zero gives canonical quiet NaN {0, all-ones, 1 followed by zeros}; infinity x non-zero gives signed infinity; ovf=unf=0 for these cases.
REQ-029 Without FMUL_PIPE_SPECIAL_EN, all-ones exponents are ordinary finite values processed by REQ-019..025; no NaN is generated.

Verification
REQ-030 Defaults, out_ready=1: x1=0x3FC00000, x2=0x40000000 -> y=0x40400000, ovf=0, unf=0, exactly 3 cycles after accept.
REQ-031 x1=0xBF800000, x2=0x40000000 -> y=0xC0000000; x1=0x00000000, x2=0xC0400000 -> y=0x80000000.
REQ-032 x1=0x7F000000, x2=0x7F000000 -> y=0x7F800000, ovf=1; x1=0x00800000, x2=0x00800000 -> y=0x00000000, unf=1.
REQ-033 Stream 6 back-to-back operations, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0, y stable, all 6 results delivered in order, none lost.
REQ-034 Assert rst with 3 operations in flight -> out_valid=0 immediately; after release no stale result appears.
REQ-035 With FMUL_PIPE_SPECIAL_EN: x1=0x7F800000, x2=0x00000000 -> y=0x7FC00000; x1=0xFF800000, x2=0x40000000 -> y=0xFF800000, ovf=0.

Source files
------------

// File: rtl/fmul_pipe.sv
// +----------------------------------------------------------------------------+
// | fmul_pipe : 3-stage pipelined floating-point multiplier (RNE, flush-to-0)  |
// | Optional IEEE NaN/Inf handling: define FMUL_PIPE_SPECIAL_EN                |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fmul_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = 2 * MW + 2;
  localparam logic [EW+1:0] BIAS = {3'b000, {(EW-1){1'b1}}};

  // Operation class carried down the pipe; INF/NAN only arise with special handling
  localparam logic [1:0] CLS_NUM  = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  logic advance;

  logic          v1_q, v1_d, sign1_q, sign1_d;
  logic [1:0]    cls1_q, cls1_d;
  logic [EW+1:0] exp1_q, exp1_d;
  logic [PW-1:0] prod1_q, prod1_d;

  logic          v2_q, v2_d, sign2_q, sign2_d;
  logic [1:0]    cls2_q, cls2_d;
  logic [EW+1:0] exp2_q, exp2_d;
  logic [MW-1:0] mant2_q, mant2_d;

  logic          out_valid_q, out_valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [EW+MW:0] y_q, y_d;

  logic [EW-1:0] e1, e2;
  logic [MW-1:0] m1, m2;
  logic          z1, z2;

  logic          msb, guard, sticky, rnd;
  logic [MW-1:0] mant;
  logic [MW:0]   mant_r;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  assign e1 = x1[EW+MW-1:MW];
  assign e2 = x2[EW+MW-1:MW];
  assign m1 = x1[MW-1:0];
  assign m2 = x2[MW-1:0];
  assign z1 = (e1 == '0);
  assign z2 = (e2 == '0);

  // S1: unpack, sign, full mantissa product, biased exponent sum
  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    cls1_d  = cls1_q;
    exp1_d  = exp1_q;
    prod1_d = prod1_q;
    if (advance) begin
      v1_d    = in_valid;
      sign1_d = x1[EW+MW] ^ x2[EW+MW];
      exp1_d  = {2'b00, e1} + {2'b00, e2} - BIAS;
      prod1_d = PW'({1'b1, m1}) * PW'({1'b1, m2});
`ifdef FMUL_PIPE_SPECIAL_EN
      if (((&e1) && (|m1)) || ((&e2) && (|m2)) ||
          ((&e1) && z2) || ((&e2) && z1))
        cls1_d = CLS_NAN;
      else if ((&e1) || (&e2))
        cls1_d = CLS_INF;
      else if (z1 || z2)
        cls1_d = CLS_ZERO;
      else
        cls1_d = CLS_NUM;
`else
      cls1_d = (z1 || z2) ? CLS_ZERO : CLS_NUM;
`endif
    end
  end

  // S2: normalise by at most one place, then round to nearest even
  always_comb begin
    msb    = prod1_q[PW-1];
    mant   = msb ? prod1_q[PW-2:MW+1] : prod1_q[PW-3:MW];
    guard  = msb ? prod1_q[MW] : prod1_q[MW-1];
    sticky = msb ? (|prod1_q[MW-1:0]) : (|prod1_q[MW-2:0]);
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + (MW+1)'(rnd);

    v2_d    = v2_q;
    sign2_d = sign2_q;
    cls2_d  = cls2_q;
    exp2_d  = exp2_q;
    mant2_d = mant2_q;
    if (advance) begin
      v2_d    = v1_q;
      sign2_d = sign1_q;
      cls2_d  = cls1_q;
      // A rounding carry leaves mant_r[MW-1:0] all zero, which is already 1.0
      exp2_d  = exp1_q + (EW+2)'(msb) + (EW+2)'(mant_r[MW]);
      mant2_d = mant_r[MW-1:0];
    end
  end

  // S3: range check, pack and flag; outputs only change on a valid advance
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (advance) begin
      out_valid_d = v2_q;
      if (v2_q) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (cls2_q)
          CLS_ZERO: y_d = {sign2_q, {(EW+MW){1'b0}}};
          CLS_INF:  y_d = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
          CLS_NAN:  y_d = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
          default: begin
            if (!exp2_q[EW+1] && (exp2_q[EW:0] >= {1'b0, {EW{1'b1}}})) begin
              y_d   = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
              ovf_d = 1'b1;
            end else if (exp2_q[EW+1] || (exp2_q == '0)) begin
              y_d   = {sign2_q, {(EW+MW){1'b0}}};
              unf_d = 1'b1;
            end else begin
              y_d = {sign2_q, exp2_q[EW-1:0], mant2_q};
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      cls1_q      <= CLS_NUM;
      exp1_q      <= '0;
      prod1_q     <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      cls2_q      <= CLS_NUM;
      exp2_q      <= '0;
      mant2_q     <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      cls1_q      <= cls1_d;
      exp1_q      <= exp1_d;
      prod1_q     <= prod1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      cls2_q      <= cls2_d;
      exp2_q      <= exp2_d;
      mant2_q     <= mant2_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fmul_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_fmul_pipe : randomized self-checking bench for fmul_pipe (defaults)     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf, unf;
  logic [31:0] x1, x2, y;

  fmul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic        took;
  logic        lat_chk = 1'b0;
  logic        dir_use = 1'b0;
  logic [33:0] dir_exp = '0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: exact integer product, rounded by remainder comparison; returns {ovf,unf,y}
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic       s;
    int         ea, eb, lead, sh, e;
    longint     p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FMUL_PIPE_SPECIAL_EN
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
      return {2'b00, 32'h7FC00000};
    if (ea == 255 || eb == 255)
      return {2'b00, s, 8'hFF, 23'd0};
`endif
    if (ea == 0 || eb == 0)
      return {2'b00, s, 31'd0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    lead = 0;
    for (int i = 0; i < 48; i++)
      if (p[i]) lead = i;
    sh   = lead - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0]))
      q = q + 1;
    e = ea + eb - 127 + (lead - 46);
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int         k;
    k = int'($urandom_range(0, 9));
    case (k)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 12));
      4, 5:    e = 8'($urandom_range(240, 254));
      default: e = 8'($urandom_range(60, 195));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t ent;
    cyc++;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (prev_stall)
        chk("stall_hold", {29'd0, out_valid, ovf, unf, y}, {29'd0, 1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          ent = sb.pop_front();
          chk("result", {30'd0, ovf, unf, y}, {30'd0, ent.res});
          if (lat_chk)
            chk("latency", 64'(cyc - ent.cyc), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        ent.res = dir_use ? dir_exp : ref_mul(x1, x2);
        ent.cyc = cyc;
        sb.push_back(ent);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {ovf, unf, y};
    end
  end

  task automatic step();
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input logic [31:0] a, input logic [31:0] b, input logic [33:0] e);
    x1 = a; x2 = b; dir_exp = e; dir_use = 1'b1; in_valid = 1'b1;
    step();
    chk("dir_accept", {63'd0, took}, 64'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() > 0; k++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int sent, stall_left;
    logic stalled;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x1 = '0; x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y_flags", {30'd0, ovf, unf, y}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    step();

    // Directed vectors, back-to-back, out_ready high: latency checked on each
    lat_chk = 1'b1;
    send_dir(32'h3FC00000, 32'h40000000, {2'b00, 32'h40400000});
    send_dir(32'hBF800000, 32'h40000000, {2'b00, 32'hC0000000});
    send_dir(32'h00000000, 32'hC0400000, {2'b00, 32'h80000000});
    send_dir(32'h7F000000, 32'h7F000000, {2'b10, 32'h7F800000});
    send_dir(32'h00800000, 32'h00800000, {2'b01, 32'h00000000});
    send_dir(32'h3F800001, 32'h3FC00000, {2'b00, 32'h3FC00002});
    send_dir(32'h3FFFFFFE, 32'h3F800001, {2'b00, 32'h40000000});
    send_dir(32'h7E800000, 32'h40000000, {2'b00, 32'h7F000000});
    send_dir(32'h7F000000, 32'h40000000, {2'b10, 32'h7F800000});
    send_dir(32'h00800000, 32'h3F800000, {2'b00, 32'h00800000});
    send_dir(32'h00800000, 32'h3F000000, {2'b01, 32'h00000000});
    send_dir(32'h80800000, 32'h3F000000, {2'b01, 32'h80000000});
    send_dir(32'hFF000000, 32'h7F000000, {2'b10, 32'hFF800000});
    send_dir(32'h80000000, 32'h80000000, {2'b00, 32'h00000000});
`ifdef FMUL_PIPE_SPECIAL_EN
    send_dir(32'h7F800000, 32'h00000000, {2'b00, 32'h7FC00000});
    send_dir(32'hFF800000, 32'h40000000, {2'b00, 32'hFF800000});
    send_dir(32'h7FC00001, 32'h3F800000, {2'b00, 32'h7FC00000});
    send_dir(32'h7F800000, 32'hFF800000, {2'b00, 32'hFF800000});
`else
    send_dir(32'h7F800000, 32'h3F800000, {2'b10, 32'h7F800000});
    send_dir(32'hFF800001, 32'h3F000000, {2'b00, 32'hFF000001});
`endif
    dir_use = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Six back-to-back operations with a five-cycle consumer stall
    sent = 0; stalled = 1'b0; stall_left = 0;
    x1 = rand_op(); x2 = rand_op(); in_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step();
      if (took) begin
        sent++;
        if (sent == 6) in_valid = 1'b0;
        else begin x1 = rand_op(); x2 = rand_op(); end
      end
      if (!stalled && out_valid) begin
        stalled = 1'b1; out_ready = 1'b0; stall_left = 5;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end
      if (sent == 6 && stalled && stall_left == 0) break;
    end
    chk("stream_sent", 64'(sent), 64'd6);
    drain();

    // Random traffic with random back-pressure
    in_valid = 1'b0;
    for (int k = 0; k < 800; k++) begin
      step();
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 7);
        x1 = rand_op(); x2 = rand_op();
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    drain();

    // Reset with operations in flight
    out_ready = 1'b1; in_valid = 1'b1;
    x1 = rand_op(); x2 = rand_op();
    for (int i = 0; i < 3; i++) begin
      step();
      x1 = rand_op(); x2 = rand_op();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_y_flags", {30'd0, ovf, unf, y}, 64'd0);
    step();
    rst = 1'b0;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("no_stale_out", {63'd0, out_valid}, 64'd0);
    end

    // Traffic after reset still flows correctly
    for (int k = 0; k < 100; k++) begin
      step();
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 9) < 8);
        x1 = rand_op(); x2 = rand_op();
      end
      out_ready = ($urandom_range(0, 9) < 6);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
